ahb_lite_mem_slave: RTL
=======================

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Parameters
REQ-001 The block SHALL have parameter HADDR_SIZE, default 32, giving the address bus width in bits.
REQ-002 The block SHALL have parameter HDATA_SIZE, default 32, giving the data bus width in bits; legal values are 32 and 64.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of HDATA_SIZE-wide words; it SHALL be a power of 2.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, giving the number of extra data-phase wait cycles per OKAY transfer; legal range is 0..7.

Interface
REQ-005 HCLK  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-006 HRESETn  in  1  reset; asynchronous, active-low.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  HADDR_SIZE  byte address.
REQ-009 HWDATA  in  HDATA_SIZE  write data, sampled in the data phase.
REQ-010 HRDATA  out  HDATA_SIZE  read data.
REQ-011 HWRITE  in  1  1=write, 0=read.
REQ-012 HSIZE  in  3  transfer size: 0=byte, 1=half, 2=word, 3=dword.
REQ-013 HBURST  in  3  burst type; accepted and ignored, since each beat is handled independently.
REQ-014 HPROT  in  4  protection; accepted and ignored.
REQ-015 HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-016 HREADY  in  1  bus ready (mux of all slaves' HREADYOUT).
REQ-017 HREADYOUT  out  1  slave ready.
REQ-018 HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-019 An address phase SHALL be accepted only on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are then registered for the data phase.
REQ-020 If HSEL=0 or HTRANS is IDLE/BUSY with HREADY=1, the next cycle SHALL give a zero-wait OKAY response (HREADYOUT=1, HRESP=0) with no memory access.
REQ-021 The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2; IDLE is the state on reset.
REQ-022 A legal accepted transfer SHALL enter WAIT when WAIT_STATES>0, otherwise DATA.
REQ-023 WAIT SHALL count down WAIT_STATES cycles with HREADYOUT=0 and HRESP=0, then go to DATA.
REQ-024 DATA SHALL drive HREADYOUT=1 and HRESP=0 for one cycle.
REQ-025 In DATA, a new accepted transfer SHALL chain directly into WAIT/DATA/ERR1; otherwise the FSM SHALL return to IDLE.
REQ-026 A transfer SHALL be illegal when any of these hold: HSIZE > log2(HDATA_SIZE/8); address not aligned to 2^HSIZE; word index (HADDR >> log2(HDATA_SIZE/8)) >= MEM_DEPTH.
REQ-027 An illegal transfer SHALL enter ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), with no memory update; wait states SHALL NOT be applied.
REQ-028 Write byte lanes SHALL be little-endian: lanes [addr_lo +: 2^HSIZE] are written from the same HWDATA lanes, and all other bytes are preserved.
REQ-029 The write SHALL commit on the final data-phase edge (HREADYOUT=1); HWDATA is sampled only on that edge.
REQ-030 Read HRDATA SHALL be the full addressed word, valid while HREADYOUT=1 in DATA; in all other states HRDATA SHALL be 0.
REQ-031 Read-after-write hazard: a read whose data phase immediately follows a write's data phase to the same word SHALL return the merged, newly written data (bypass); zero extra latency is permitted.
REQ-032 Memory contents SHALL NOT be initialised.
REQ-033 When HREADY=0 (another slave stalling), the block SHALL NOT accept a new address phase.

Reset
REQ-034 While HRESETn=0: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, registered address phase cleared.
REQ-035 If reset is asserted during WAIT/DATA/ERR1, the in-flight write SHALL be discarded and memory left unchanged.
REQ-036 After HRESETn rises, the first rising edge SHALL be able to accept an address phase.

Verification
REQ-037 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> read data phase HRDATA=0xDEADBEEF, zero waits (bypass).
REQ-038 Byte write 0xAA to @0x13 over word 0x11223344 -> read @0x10 returns 0xAA223344.
REQ-039 WAIT_STATES=3: read @0x0 -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data.
REQ-040 Read @0x400 with MEM_DEPTH=256 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); half-word write @0x01 -> same two-cycle ERROR, memory unchanged.
REQ-041 Incrementing burst (INCR4, NONSEQ+3xSEQ, one BUSY inserted) at @0x20 -> 4 beats written, BUSY gives OKAY with no write.
REQ-042 Assert HRESETn=0 mid-WAIT of a write to @0x8 -> outputs immediately reach reset values and @0x8 is unchanged.

Source files
------------

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite single-port memory slave with byte-lane writes, optional data-phase wait states,
// two-cycle ERROR for illegal transfers and read-after-write bypass.
module ahb_lite_mem_slave #(
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int         BYTES    = HDATA_SIZE / 8;
   localparam int         BE_W     = $clog2(BYTES);
   localparam int         IDX_W    = $clog2(MEM_DEPTH);
   localparam logic [2:0] MAX_SIZE = 3'(BE_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [BE_W-1:0]       off_q, off_d;
   logic [2:0]            size_q, size_d;
   logic                  write_q, write_d;

   logic                  accept;
   logic                  can_accept;
   logic                  take;
   logic                  size_bad;
   logic                  align_bad;
   logic                  range_bad;
   logic                  legal;
   logic [2:0]            lo_mask;
   logic [HADDR_SIZE-1:0] word_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_en;
   logic                  wr_en;
   logic                  hit;
   logic [BYTES-1:0]      be;

   logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
   logic [HDATA_SIZE-1:0] rd_word_q;

   // Burst type, protection and the NONSEQ/SEQ distinction do not affect a beat.
   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

   // ---------------------------------------------------------------- address-phase decode
   always_comb begin
      case (HSIZE)
         3'd0:    lo_mask = 3'b000;
         3'd1:    lo_mask = 3'b001;
         3'd2:    lo_mask = 3'b011;
         default: lo_mask = 3'b111;
      endcase
   end

   assign accept     = HSEL & HREADY & HTRANS[1];
   assign can_accept = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
   assign take       = accept & can_accept;
   assign size_bad   = HSIZE > MAX_SIZE;
   assign align_bad  = |(HADDR[2:0] & lo_mask);
   assign word_idx   = HADDR >> BE_W;
   assign range_bad  = word_idx >= HADDR_SIZE'(MEM_DEPTH);
   assign legal      = ~(size_bad | align_bad | range_bad);
   assign rd_idx     = HADDR[BE_W +: IDX_W];

   // ---------------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before any branch so no path leaves it
   // unassigned, which is what keeps synthesis from inferring a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      off_d   = off_q;
      size_d  = size_q;
      write_d = write_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 3'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new beat may chain in.
            if (take) begin
               idx_d   = rd_idx;
               off_d   = HADDR[BE_W-1:0];
               size_d  = HSIZE;
               write_d = HWRITE;
               if (!legal) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 3'(WAIT_STATES - 1);
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values of the others, independent of process evaluation order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // ---------------------------------------------------------------- response
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         ST_WAIT: HREADYOUT = 1'b0;
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         ST_ERR2: HRESP = 1'b1;
         default: ;
      endcase
   end

   assign HRDATA = (state_q == ST_DATA && !write_q) ? rd_word_q : '0;

   // ---------------------------------------------------------------- storage
   always_comb begin
      be = '0;
      for (int b = 0; b < BYTES; b++) begin
         be[b] = (b >= int'(off_q)) && (b < int'(off_q) + int'(32'd1 << size_q));
      end
   end

   // A write commits on the last edge of its DATA cycle; a reset that has already forced
   // IDLE therefore drops any write still in flight.
   assign wr_en = (state_q == ST_DATA) & write_q;
   assign rd_en = take & legal & ~HWRITE;
   assign hit   = rd_idx == idx_q;

   // NOTE: the array and its read register are deliberately left out of reset so the
   // storage maps onto a byte-enabled RAM; HRDATA is gated by state instead.
   always_ff @(posedge HCLK) begin
      for (int b = 0; b < BYTES; b++) begin
         if (wr_en && be[b]) begin
            mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
         // A read accepted on the same edge as a write to its word takes the new lanes.
         if (rd_en) begin
            rd_word_q[8*b +: 8] <= (wr_en && be[b] && hit) ? HWDATA[8*b +: 8]
                                                          : mem[rd_idx][8*b +: 8];
         end
      end
   end

endmodule
